hier_leaf_stage: RTL and testbench



---
 rtl/hier_leaf_stage.sv | 183 ++++++++++++++++++
 tb/tb_hier_leaf_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hier_leaf_stage.sv
// -----------------------------------------------------------------------------
// hier_leaf_stage
//
// Terminal stage of a generated hierarchy. Accepts a valid/ready stream,
// holds up to two beats in a skid buffer (head + tail registers) and forwards
// them downstream tagged with the static instance index. A saturating counter
// records how many beats have been delivered downstream.
//
// Handshake: a beat moves on a clock edge where valid and ready are both high
// on that interface. The producer keeps valid and data stable until ready is
// seen. out_valid and in_ready come from registers and never depend
// combinationally on in_valid or out_ready. in_ready is additionally held low
// while rst is high, so a beat offered during reset is never taken.
//
// Optional feature macro: HIER_LEAF_PARITY_EN
//   When defined, each entry carries an even-parity bit (^data), computed at
//   push and presented on out_parity together with its data.
//
// Parameters:
//   DATA_W  payload width
//   INST_ID instance index, driven on out_tag
//   CNT_W   width of the delivered-beat counter
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload (buffer head)
//   out_tag               constant INST_ID[3:0]
//   beat_count            saturating count of downstream handshakes
//   cnt_sat               sticky flag, set when beat_count reaches all-ones
//   dbg_state             occupancy state (0 empty, 1 one entry, 2 full)
//   out_parity            parity of out_data (HIER_LEAF_PARITY_EN only)
// -----------------------------------------------------------------------------
module hier_leaf_stage #(
    parameter int DATA_W  = 16,
    parameter int INST_ID = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_tag,
    output logic [CNT_W-1:0]  beat_count,
    output logic              cnt_sat,
    output logic [1:0]        dbg_state
`ifdef HIER_LEAF_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sat_q;

    logic              push;
    logic              pop;
    logic              load_head_in;  // incoming beat goes straight to head
    logic              load_tail_in;  // incoming beat parks in tail
    logic              move_tail;     // tail advances into head

    assign in_ready   = in_ready_q & ~rst;
    assign out_valid  = out_valid_q;
    assign out_data   = head_q;
    assign out_tag    = 4'(INST_ID);
    assign beat_count = cnt_q;
    assign cnt_sat    = sat_q;
    assign dbg_state  = state_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid_q & out_ready;

    // Next-state and datapath steering
    always_comb begin
        state_d      = state_q;
        load_head_in = 1'b0;
        load_tail_in = 1'b0;
        move_tail    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d      = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // head leaves and is replaced in the same cycle
                    load_head_in = 1'b1;
                end else if (push) begin
                    state_d      = FULL;
                    load_tail_in = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d   = ONE;
                    move_tail = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Handshake flags are decoded from the next state so they are
            // registered and line up with the occupancy they describe.
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != FULL);
            if (load_head_in) begin
                head_q <= in_data;
            end else if (move_tail) begin
                head_q <= tail_q;
            end
            if (load_tail_in) begin
                tail_q <= in_data;
            end
            if (pop && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
                // flag rises on the same edge the count lands on all-ones
                if (cnt_q == CNT_PRE) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

`ifdef HIER_LEAF_PARITY_EN
    logic head_par_q;
    logic tail_par_q;

    assign out_parity = head_par_q;

    // Parity travels with its entry using the same steering as the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_par_q <= 1'b0;
            tail_par_q <= 1'b0;
        end else begin
            if (load_head_in) begin
                head_par_q <= ^in_data;
            end else if (move_tail) begin
                head_par_q <= tail_par_q;
            end
            if (load_tail_in) begin
                tail_par_q <= ^in_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hier_leaf_stage.sv
// Self-checking bench for hier_leaf_stage. Two instances share all inputs:
// the main one (INST_ID=5, CNT_W=16) and a narrow-counter one (INST_ID=10,
// CNT_W=2) used to observe saturation. The reference is a queue of pending
// beats with capacity two plus a plain integer count of delivered beats.
module tb_hier_leaf_stage;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready, out_valid, cnt_sat;
  logic [DW-1:0] out_data;
  logic [3:0]    out_tag;
  logic [15:0]   beat_count;
  logic [1:0]    dbg_state;

  logic          s_in_ready, s_out_valid, s_cnt_sat;
  logic [DW-1:0] s_out_data;
  logic [3:0]    s_out_tag;
  logic [1:0]    s_beat_count;
  logic [1:0]    s_dbg_state;
`ifdef HIER_LEAF_PARITY_EN
  logic          out_parity, s_out_parity;
`endif

  hier_leaf_stage #(.DATA_W(DW), .INST_ID(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .beat_count(beat_count), .cnt_sat(cnt_sat),
    .dbg_state(dbg_state)
`ifdef HIER_LEAF_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  hier_leaf_stage #(.DATA_W(DW), .INST_ID(10), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_tag(s_out_tag), .beat_count(s_beat_count), .cnt_sat(s_cnt_sat),
    .dbg_state(s_dbg_state)
`ifdef HIER_LEAF_PARITY_EN
    , .out_parity(s_out_parity)
`endif
  );

  // Reference model
  logic [DW-1:0] exp_q[$];
  int            pops;
  int            n_checks;
  int            n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every observable output against the model (called mid-cycle).
  task automatic check_all();
    int exp_cnt, exp_scnt;
    exp_cnt  = (pops > 65535) ? 65535 : pops;
    exp_scnt = (pops > 3) ? 3 : pops;
    chk("in_ready",   32'(in_ready),   32'(!rst && exp_q.size() < 2));
    chk("out_valid",  32'(out_valid),  32'(exp_q.size() > 0));
    chk("beat_count", 32'(beat_count), 32'(exp_cnt));
    chk("cnt_sat",    32'(cnt_sat),    32'(pops >= 65535));
    chk("out_tag",    32'(out_tag),    32'h5);
    chk("s_in_ready", 32'(s_in_ready), 32'(!rst && exp_q.size() < 2));
    chk("s_out_valid", 32'(s_out_valid), 32'(exp_q.size() > 0));
    chk("s_beat_count", 32'(s_beat_count), 32'(exp_scnt));
    chk("s_cnt_sat",  32'(s_cnt_sat),  32'(pops >= 3));
    chk("s_out_tag",  32'(s_out_tag),  32'ha);
    if (exp_q.size() > 0) begin
      chk("out_data",   32'(out_data),   32'(exp_q[0]));
      chk("s_out_data", 32'(s_out_data), 32'(exp_q[0]));
`ifdef HIER_LEAF_PARITY_EN
      chk("out_parity", 32'(out_parity), 32'(^exp_q[0]));
      chk("s_out_parity", 32'(s_out_parity), 32'(^exp_q[0]));
`endif
    end
  endtask

  // Drive one cycle of inputs (starting at a negedge), advance the model on
  // the posedge, then check at the following negedge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    logic will_push, will_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    will_push = v && !rst && (exp_q.size() < 2);
    will_pop  = r && (exp_q.size() > 0);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      pops = 0;
    end else begin
      if (will_pop) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (will_push) exp_q.push_back(d);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    pops      = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);

    // Reset release
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h5a5a, 1'b0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
`ifdef HIER_LEAF_PARITY_EN
    chk("rst_out_parity", 32'(out_parity), 32'h0);
`endif
    rst = 1'b0;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'h1);
    check_all();

    // Streaming, no bubbles
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 16'(i), 1'b1);
      chk("stream_valid", 32'(out_valid), 32'h1);
      chk("stream_data", 32'(out_data), 32'(i));
    end
    cycle(1'b0, '0, 1'b1);
    chk("stream_count", 32'(beat_count), 32'd8);

    // Backpressure: third beat must be refused
    cycle(1'b1, 16'haaaa, 1'b0);
    cycle(1'b1, 16'hbbbb, 1'b0);
    chk("bp_full_ready", 32'(in_ready), 32'h0);
    cycle(1'b1, 16'hcccc, 1'b0);
    cycle(1'b1, 16'hcccc, 1'b0);
    chk("bp_hold_data", 32'(out_data), 32'haaaa);
    cycle(1'b0, '0, 1'b1);
    chk("bp_second", 32'(out_data), 32'hbbbb);
    cycle(1'b0, '0, 1'b1);
    chk("bp_drained", 32'(out_valid), 32'h0);

    // Mid-stream reset while full
    cycle(1'b1, 16'h1111, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    cycle(1'b1, 16'h3333, 1'b0);
    chk("after_rst_data", 32'(out_data), 32'h3333);
    cycle(1'b0, '0, 1'b1);

    // Parity alignment under stall
    cycle(1'b1, 16'h0003, 1'b0);
    cycle(1'b1, 16'h0007, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
            1'($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    chk("final_empty", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
